// File: rtl/bp_me_cache_dma_mux.sv
// Merges per-bank L2 DMA channels onto one memory channel: round-robin packet
// arbitration, in-order read-return routing via a bank-ID FIFO, write-burst forwarding.
module bp_me_cache_dma_mux #(
  parameter int banks_p       = 2,
  parameter int addr_width_p  = 28,
  parameter int fill_width_p  = 64,
  parameter int beats_p       = 8,
  parameter int rd_fifo_els_p = 4,
  localparam int PktW  = 1 + addr_width_p,
  localparam int BankW = (banks_p > 1) ? $clog2(banks_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [banks_p*PktW-1:0]          dma_pkt_i,
  input  logic [banks_p-1:0]               dma_pkt_v_i,
  output logic [banks_p-1:0]               dma_pkt_ready_and_o,
  output logic [banks_p*fill_width_p-1:0]  dma_data_o,
  output logic [banks_p-1:0]               dma_data_v_o,
  input  logic [banks_p-1:0]               dma_data_ready_and_i,
  input  logic [banks_p*fill_width_p-1:0]  dma_data_i,
  input  logic [banks_p-1:0]               dma_data_v_i,
  output logic [banks_p-1:0]               dma_data_ready_and_o,
  output logic [PktW-1:0]                  mem_pkt_o,
  output logic [BankW-1:0]                 mem_pkt_bank_o,
  output logic                             mem_pkt_v_o,
  input  logic                             mem_pkt_ready_and_i,
  input  logic [fill_width_p-1:0]          mem_rdata_i,
  input  logic                             mem_rdata_v_i,
  output logic                             mem_rdata_ready_and_o,
  output logic [fill_width_p-1:0]          mem_wdata_o,
  output logic                             mem_wdata_v_o,
  input  logic                             mem_wdata_ready_and_i
);

  localparam int CntW = (beats_p > 1) ? $clog2(beats_p) : 1;
  localparam int FpW  = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int FcW  = $clog2(rd_fifo_els_p + 1);
  localparam logic [CntW-1:0]  LastBeat = CntW'(beats_p - 1);
  localparam logic [BankW-1:0] LastBank = BankW'(banks_p - 1);
  localparam logic [FpW-1:0]   LastSlot = FpW'(rd_fifo_els_p - 1);
  localparam logic [FcW-1:0]   FifoFull = FcW'(rd_fifo_els_p);

  typedef enum logic [0:0] {ST_IDLE, ST_WRITE} state_e;

  logic [banks_p-1:0][PktW-1:0]         pkt_arr;
  logic [banks_p-1:0][fill_width_p-1:0] wdat_arr;
  assign pkt_arr  = dma_pkt_i;
  assign wdat_arr = dma_data_i;

  state_e            state_q, state_d;
  logic [BankW-1:0]  ptr_q, ptr_d;
  logic [BankW-1:0]  wbank_q, wbank_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [CntW-1:0]   rcnt_q, rcnt_d;
  logic [BankW-1:0]  fifo_mem_q [rd_fifo_els_p];
  logic [FpW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FcW-1:0]    count_q, count_d;

  logic              win_found;
  logic [BankW-1:0]  win_idx;
  logic [BankW:0]    scan_idx;
  logic              win_is_write, fifo_full, fifo_nonempty;
  logic              pkt_offer, pkt_acc, push, pop;
  logic              in_write, wr_xfer, rd_ok, rd_xfer;
  logic [BankW-1:0]  head;

  // Round-robin scan starting at the pointer; first valid bank wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < banks_p; i++) begin
      scan_idx = {1'b0, ptr_q} + (BankW+1)'(i);
      if (scan_idx >= (BankW+1)'(banks_p)) scan_idx = scan_idx - (BankW+1)'(banks_p);
      if (!win_found && dma_pkt_v_i[scan_idx[BankW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[BankW-1:0];
      end
    end
  end

  assign win_is_write  = pkt_arr[win_idx][PktW-1];
  assign fifo_full     = (count_q == FifoFull);
  assign fifo_nonempty = (count_q != '0);
  // A full FIFO blocks reads even when a pop lands in the same cycle.
  assign pkt_offer     = reset_n_i && (state_q == ST_IDLE) && win_found
                         && (win_is_write || !fifo_full);
  assign pkt_acc       = pkt_offer && mem_pkt_ready_and_i;
  assign push          = pkt_acc && !win_is_write;

  assign mem_pkt_v_o    = pkt_offer;
  assign mem_pkt_o      = pkt_arr[win_idx];
  assign mem_pkt_bank_o = win_idx;

  assign in_write      = reset_n_i && (state_q == ST_WRITE);
  assign mem_wdata_v_o = in_write && dma_data_v_i[wbank_q];
  assign mem_wdata_o   = wdat_arr[wbank_q];
  assign wr_xfer       = mem_wdata_v_o && mem_wdata_ready_and_i;

  assign head                  = fifo_mem_q[rd_ptr_q];
  assign rd_ok                 = reset_n_i && fifo_nonempty;
  assign mem_rdata_ready_and_o = rd_ok && dma_data_ready_and_i[head];
  assign rd_xfer               = mem_rdata_v_i && mem_rdata_ready_and_o;
  assign pop                   = rd_xfer && (rcnt_q == LastBeat);
  assign dma_data_o            = {banks_p{mem_rdata_i}};

  always_comb begin
    dma_pkt_ready_and_o  = '0;
    dma_data_ready_and_o = '0;
    dma_data_v_o         = '0;
    for (int b = 0; b < banks_p; b++) begin
      dma_pkt_ready_and_o[b]  = pkt_acc && (win_idx == BankW'(b));
      dma_data_ready_and_o[b] = in_write && mem_wdata_ready_and_i && (wbank_q == BankW'(b));
      dma_data_v_o[b]         = rd_ok && mem_rdata_v_i && (head == BankW'(b));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pkt_acc) begin
          ptr_d = (win_idx == LastBank) ? '0 : win_idx + 1'b1;
          if (win_is_write) begin
            state_d = ST_WRITE;
            wbank_d = win_idx;
            wcnt_d  = '0;
          end
        end
      end
      ST_WRITE: begin
        if (wr_xfer) begin
          if (wcnt_q == LastBeat) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rcnt_d   = rcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rd_xfer) rcnt_d = pop ? '0 : rcnt_q + 1'b1;
    if (push) wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      wbank_q  <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < rd_fifo_els_p; k++) fifo_mem_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wbank_q  <= wbank_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) fifo_mem_q[wr_ptr_q] <= win_idx;
    end
  end

endmodule

// File: tb/tb_bp_me_cache_dma_mux.sv
// Directed + randomized bench for bp_me_cache_dma_mux with a queue-based
// reference model of outstanding reads and a round-robin pointer model.
module tb_bp_me_cache_dma_mux;

  localparam int BANKS = 2;
  localparam int AW    = 28;
  localparam int FW    = 64;
  localparam int BEATS = 8;
  localparam int ELS   = 4;

  logic clk;
  logic reset_n;
  logic [BANKS-1:0][AW:0]   pkt;
  logic [BANKS-1:0]         pkt_v, pkt_rdy;
  logic [BANKS-1:0][FW-1:0] fill_d;
  logic [BANKS-1:0]         fill_v, fill_rdy;
  logic [BANKS-1:0][FW-1:0] ev_d;
  logic [BANKS-1:0]         ev_v, ev_rdy;
  logic [AW:0]              mpkt;
  logic                     mbank;
  logic                     mpkt_v, mpkt_rdy;
  logic [FW-1:0]            rdata;
  logic                     rdata_v, rdata_rdy;
  logic [FW-1:0]            wdata;
  logic                     wdata_v, wdata_rdy;

  int errors = 0;
  int checks = 0;
  int q[$];
  int rbeat = 0;
  int rr_ptr = 0;

  bp_me_cache_dma_mux #(
    .banks_p(BANKS), .addr_width_p(AW), .fill_width_p(FW),
    .beats_p(BEATS), .rd_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_ready_and_o(pkt_rdy),
    .dma_data_o(fill_d), .dma_data_v_o(fill_v), .dma_data_ready_and_i(fill_rdy),
    .dma_data_i(ev_d), .dma_data_v_i(ev_v), .dma_data_ready_and_o(ev_rdy),
    .mem_pkt_o(mpkt), .mem_pkt_bank_o(mbank), .mem_pkt_v_o(mpkt_v),
    .mem_pkt_ready_and_i(mpkt_rdy),
    .mem_rdata_i(rdata), .mem_rdata_v_i(rdata_v), .mem_rdata_ready_and_o(rdata_rdy),
    .mem_wdata_o(wdata), .mem_wdata_v_o(wdata_v), .mem_wdata_ready_and_i(wdata_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read-return model: head bank of the outstanding-read queue receives beats;
  // after BEATS accepted beats the head retires.
  task automatic rd_model(input string tag);
    int h;
    logic er;
    logic [1:0] ev;
    h  = (q.size() > 0) ? q[0] : 0;
    er = (q.size() > 0) && fill_rdy[h];
    ev = (q.size() > 0 && rdata_v) ? (2'b01 << h) : 2'b00;
    chk({tag, "_rrdy"}, 64'(rdata_rdy), 64'(er));
    chk({tag, "_fv"}, 64'(fill_v), 64'(ev));
    if (ev != 2'b00) chk({tag, "_fd"}, fill_d[h], rdata);
    if (rdata_v && er) begin
      rbeat++;
      if (rbeat == BEATS) begin
        void'(q.pop_front());
        rbeat = 0;
      end
    end
  endtask

  initial begin
    logic [FW-1:0] wdat [BEATS];
    int wbeats, xfers, exp_w;
    logic wtog, granted, exp_v;

    reset_n = 1'b0; pkt = '0; pkt_v = '0; fill_rdy = '0; ev_d = '0; ev_v = '0;
    mpkt_rdy = 1'b0; rdata = '0; rdata_v = 1'b0; wdata_rdy = 1'b0;
    #1;
    pkt_v = 2'b11; mpkt_rdy = 1'b1; rdata_v = 1'b1; fill_rdy = 2'b11; wdata_rdy = 1'b1;
    #1;
    chk("rst_pkt_v", 64'(mpkt_v), 0);
    chk("rst_pkt_rdy", 64'(pkt_rdy), 0);
    chk("rst_wdata_v", 64'(wdata_v), 0);
    chk("rst_ev_rdy", 64'(ev_rdy), 0);
    chk("rst_rdata_rdy", 64'(rdata_rdy), 0);
    chk("rst_fill_v", 64'(fill_v), 0);
    pkt_v = '0; rdata_v = 1'b0; wdata_rdy = 1'b0;
    next_cyc();
    reset_n = 1'b1;
    #1;
    chk("idle_pkt_v", 64'(mpkt_v), 0);
    next_cyc();

    // Two reads compete: bank0 then bank1 on consecutive cycles.
    pkt[0] = {1'b0, 28'h100}; pkt[1] = {1'b0, 28'h200}; pkt_v = 2'b11; mpkt_rdy = 1'b1;
    #1;
    chk("t1_v0", 64'(mpkt_v), 1);
    chk("t1_bank0", 64'(mbank), 0);
    chk("t1_pkt0", 64'(mpkt), 64'h100);
    chk("t1_rdy0", 64'(pkt_rdy), 2'b01);
    q.push_back(0); rr_ptr = 1;
    next_cyc();
    pkt_v = 2'b10;
    #1;
    chk("t1_v1", 64'(mpkt_v), 1);
    chk("t1_bank1", 64'(mbank), 1);
    chk("t1_pkt1", 64'(mpkt), 64'h200);
    chk("t1_rdy1", 64'(pkt_rdy), 2'b10);
    q.push_back(1); rr_ptr = 0;
    next_cyc();
    pkt_v = '0;

    // 16 return beats: first 8 to bank0, next 8 to bank1.
    fill_rdy = 2'b11;
    for (int i = 0; i < 2*BEATS; i++) begin
      rdata = {$urandom, $urandom}; rdata_v = 1'b1;
      #1;
      chk("t2_route", 64'(fill_v), (i < BEATS) ? 64'd1 : 64'd2);
      rd_model("t2");
      next_cyc();
    end
    rdata_v = 1'b1;
    #1;
    chk("t2_empty_rrdy", 64'(rdata_rdy), 0);
    chk("t2_empty_fv", 64'(fill_v), 0);
    rdata_v = 1'b0;
    next_cyc();

    // Write burst from bank1 with toggling memory ready; bank0 read waits.
    pkt[1] = {1'b1, 28'h300}; pkt_v = 2'b10;
    #1;
    chk("t3_wgrant", 64'(mpkt_v), 1);
    chk("t3_wbank", 64'(mbank), 1);
    chk("t3_wrdy", 64'(pkt_rdy), 2'b10);
    rr_ptr = 0;
    next_cyc();
    for (int i = 0; i < BEATS; i++) wdat[i] = {$urandom, $urandom};
    pkt[0] = {1'b0, 28'h400}; pkt_v = 2'b01; ev_v = 2'b10;
    wbeats = 0; xfers = 0; wtog = 1'b1; granted = 1'b0;
    for (int c = 0; c < 40 && !granted; c++) begin
      ev_d[1] = wdat[(wbeats < BEATS) ? wbeats : BEATS-1];
      wdata_rdy = wtog;
      #1;
      chk("t3_pkt_v", 64'(mpkt_v), 64'(wbeats == BEATS));
      if (wbeats < BEATS) begin
        chk("t3_wv", 64'(wdata_v), 1);
        chk("t3_wd", wdata, wdat[wbeats]);
        chk("t3_evrdy", 64'(ev_rdy), wtog ? 64'd2 : 64'd0);
        if (wtog) wbeats++;
      end else begin
        chk("t3_rbank", 64'(mbank), 0);
        chk("t3_rrdy", 64'(pkt_rdy), 2'b01);
        q.push_back(0); rr_ptr = 1; granted = 1'b1;
      end
      if (wdata_v && wdata_rdy) xfers++;
      wtog = ~wtog;
      next_cyc();
    end
    chk("t3_granted", 64'(granted), 1);
    chk("t3_xfers", 64'(xfers), BEATS);
    pkt_v = '0; ev_v = '0; wdata_rdy = 1'b0;

    // Bank0 fill stalled while memory presents data; then released.
    fill_rdy = 2'b10; rdata = 64'hDEAD_BEEF_0000_0001; rdata_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_stall", 64'(rdata_rdy), 0);
      rd_model("t5s");
      next_cyc();
    end
    fill_rdy = 2'b11;
    for (int i = 0; i < BEATS; i++) begin
      if (i > 0) rdata = {$urandom, $urandom};
      #1;
      rd_model("t5r");
      next_cyc();
    end
    #1;
    chk("t5_drained", 64'(rdata_rdy), 0);
    rdata_v = 1'b0;
    next_cyc();

    // Five reads with no returns: four accepted, fifth held until a head retires.
    pkt_v = 2'b01; mpkt_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pkt[0] = {1'b0, 28'($urandom)};
      #1;
      exp_v = (q.size() < ELS);
      chk("t4_pv", 64'(mpkt_v), 64'(exp_v));
      chk("t4_prdy", 64'(pkt_rdy), exp_v ? 64'd1 : 64'd0);
      if (exp_v) begin q.push_back(0); rr_ptr = 1; end
      next_cyc();
    end
    chk("t4_full_v", 64'(mpkt_v), 0);
    rdata_v = 1'b1; fill_rdy = 2'b11; granted = 1'b0;
    for (int c = 0; c < 12 && !granted; c++) begin
      rdata = {$urandom, $urandom};
      #1;
      exp_v = (q.size() < ELS);
      chk("t4_hold_v", 64'(mpkt_v), 64'(exp_v));
      rd_model("t4r");
      if (exp_v) begin q.push_back(0); rr_ptr = 1; granted = 1'b1; end
      next_cyc();
    end
    chk("t4_granted", 64'(granted), 1);
    pkt_v = '0; rdata_v = 1'b0;

    // Random read traffic against the queue and round-robin models.
    for (int c = 0; c < 300; c++) begin
      pkt[0] = {1'b0, 28'($urandom)}; pkt[1] = {1'b0, 28'($urandom)};
      pkt_v = 2'($urandom); mpkt_rdy = 1'($urandom);
      rdata = {$urandom, $urandom}; rdata_v = 1'($urandom); fill_rdy = 2'($urandom);
      #1;
      exp_w = -1;
      for (int k = 0; k < BANKS; k++) begin
        int b;
        b = (rr_ptr + k) % BANKS;
        if (exp_w < 0 && pkt_v[b]) exp_w = b;
      end
      exp_v = (exp_w >= 0) && (q.size() < ELS);
      chk("rnd_pv", 64'(mpkt_v), 64'(exp_v));
      if (exp_v) begin
        chk("rnd_bank", 64'(mbank), 64'(exp_w));
        chk("rnd_pkt", 64'(mpkt), 64'(pkt[exp_w]));
        chk("rnd_prdy", 64'(pkt_rdy), mpkt_rdy ? (64'd1 << exp_w) : 64'd0);
      end else begin
        chk("rnd_prdy0", 64'(pkt_rdy), 0);
      end
      rd_model("rnd");
      if (exp_v && mpkt_rdy) begin
        q.push_back(exp_w);
        rr_ptr = (exp_w + 1) % BANKS;
      end
      next_cyc();
    end
    pkt_v = '0;
    for (int c = 0; c < 400 && q.size() > 0; c++) begin
      rdata = {$urandom, $urandom}; rdata_v = 1'($urandom); fill_rdy = 2'($urandom);
      #1;
      rd_model("drn");
      next_cyc();
    end
    chk("drn_done", 64'(q.size()), 0);
    rdata_v = 1'b0;

    // Reset during beat 3 of a write burst.
    pkt[0] = {1'b1, 28'h500}; pkt_v = 2'b01; mpkt_rdy = 1'b1;
    #1;
    chk("t6_wgrant", 64'(mpkt_v), 1);
    chk("t6_wbank", 64'(mbank), 0);
    next_cyc();
    pkt_v = '0; ev_v = 2'b01; wdata_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ev_d[0] = {$urandom, $urandom};
      #1;
      chk("t6_wv", 64'(wdata_v), 1);
      next_cyc();
    end
    pkt[0] = {1'b0, 28'h600}; pkt[1] = {1'b0, 28'h700};
    pkt_v = 2'b11; rdata_v = 1'b1; fill_rdy = 2'b11;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_pkt_v", 64'(mpkt_v), 0);
    chk("t6_pkt_rdy", 64'(pkt_rdy), 0);
    chk("t6_wdata_v", 64'(wdata_v), 0);
    chk("t6_ev_rdy", 64'(ev_rdy), 0);
    chk("t6_rdata_rdy", 64'(rdata_rdy), 0);
    chk("t6_fill_v", 64'(fill_v), 0);
    next_cyc();
    reset_n = 1'b1; ev_v = '0; q.delete(); rbeat = 0; rr_ptr = 0;
    #1;
    chk("t6_post_v", 64'(mpkt_v), 1);
    chk("t6_post_bank", 64'(mbank), 0);
    chk("t6_post_wv", 64'(wdata_v), 0);
    chk("t6_post_rrdy", 64'(rdata_rdy), 0);
    chk("t6_post_fv", 64'(fill_v), 0);
    next_cyc();
    pkt_v = '0; rdata_v = 1'b0;
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
